// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock controller: digit entry, code check, retry limit, timed lockout
// with BCD countdown on the display, and a patterned square-wave buzzer.
module keypad_lock_ctrl #(
  parameter int                  DIGITS    = 3,
  parameter int                  CLK_HZ    = 50_000_000,
  parameter int                  MAX_TRIES = 3,
  parameter int                  LOCK_SECS = 20,
  parameter logic [4*DIGITS-1:0] DEF_CODE  = 12'h246,
  parameter int                  CLICK_CYC = 10_000_000,
  parameter int                  HALF_KEY  = 50_000,
  parameter int                  HALF_SUCC = 25_000,
  parameter int                  HALF_FAIL = 100_000
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [15:0]           onehot,
  output logic [4*DIGITS-1:0]   disp,
  output logic [1:0]            state,
  output logic [3:0]            tries,
  output logic [6:0]            lock_secs,
  output logic [4*DIGITS-1:0]   code_out,
  output logic                  buzzer
);
  localparam int DW   = 4*DIGITS;
  localparam int CW   = $clog2(DIGITS+1);
  localparam int TW   = $clog2(CLK_HZ+1);
  localparam int PW   = $clog2(3*CLICK_CYC+1);
  localparam int HMAX = (HALF_KEY > HALF_SUCC) ? ((HALF_KEY > HALF_FAIL) ? HALF_KEY : HALF_FAIL)
                                               : ((HALF_SUCC > HALF_FAIL) ? HALF_SUCC : HALF_FAIL);
  localparam int HW   = $clog2(HMAX+1);

  localparam logic [3:0] K_ENTER = 4'd10, K_SET = 4'd11, K_CLEAR = 4'd12, K_BKSP = 4'd13;
  localparam logic [DW-1:0] BLANK  = {DIGITS{4'hF}};
  localparam logic [DW-1:0] DASHES = {DIGITS{4'hD}};
  localparam logic [DW-1:0] OPENED = {DIGITS{4'hA}};

  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_SETNEW, ST_LOCK} st_t;
  typedef enum logic [1:0] {PAT_NONE, PAT_KEY, PAT_SUCC, PAT_FAIL} pat_t;

  st_t             st_q, st_nxt;
  pat_t            pat_q;
  logic [15:0]     onehot_q;
  logic [DW-1:0]   disp_q, code_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      tries_q;
  logic [6:0]      lock_q;
  logic [TW-1:0]   tick_q;
  logic [PW-1:0]   ph_q, pat_last;
  logic [HW-1:0]   hc_q, half_last;
  logic            tone_q;

  logic [3:0]      key;
  logic            key_vld, key_ev, is_dig, full, match, tick;
  logic            acc, succ, fail;
  logic [3:0]      fill;
  logic [DW+3:0]   shl_w, shr_w;
  logic [31:0]     lk_w;

  // Exact-value decode: multi-hot and unmapped patterns fall to default.
  always_comb begin
    key     = 4'd0;
    key_vld = 1'b1;
    case (onehot)
      16'h0008: key = 4'd0;
      16'h0080: key = 4'd1;
      16'h0040: key = 4'd2;
      16'h0020: key = 4'd3;
      16'h0800: key = 4'd4;
      16'h0400: key = 4'd5;
      16'h0200: key = 4'd6;
      16'h8000: key = 4'd7;
      16'h4000: key = 4'd8;
      16'h2000: key = 4'd9;
      16'h0001: key = K_ENTER;
      16'h0010: key = K_SET;
      16'h0100: key = K_CLEAR;
      16'h1000: key = K_BKSP;
      default:  key_vld = 1'b0;
    endcase
  end

  assign key_ev = key_vld && (onehot_q == 16'h0000);
  assign is_dig = (key <= 4'd9);
  assign full   = (cnt_q == CW'(DIGITS));
  assign match  = (disp_q == code_q);
  assign tick   = (tick_q == TW'(CLK_HZ-1));
  assign fill   = (st_q == ST_SETNEW) ? 4'hD : 4'hF;
  assign shl_w  = {disp_q, key};
  assign shr_w  = {fill, disp_q};
  assign lk_w   = {24'hFFFFFF, 4'(lock_q / 7'd10), 4'(lock_q % 7'd10)};

  always_ff @(posedge clk) begin
    if (RST) st_q <= ST_ENTRY;
    else     st_q <= st_nxt;
  end

  always_comb begin
    st_nxt = st_q;
    acc    = 1'b0;
    succ   = 1'b0;
    fail   = 1'b0;
    case (st_q)
      ST_ENTRY: if (key_ev) begin
        acc = 1'b1;
        if (key == K_ENTER && full) begin
          if (match) begin
            st_nxt = ST_OPEN;
            succ   = 1'b1;
          end else begin
            fail = 1'b1;
            if (tries_q == 4'(MAX_TRIES-1)) st_nxt = ST_LOCK;
          end
        end
      end
      ST_OPEN: if (key_ev) begin
        acc = 1'b1;
        if (key == K_CLEAR)    st_nxt = ST_ENTRY;
        else if (key == K_SET) st_nxt = ST_SETNEW;
      end
      ST_SETNEW: if (key_ev) begin
        acc = 1'b1;
        if (key == K_CLEAR) st_nxt = ST_ENTRY;
        else if (key == K_ENTER && full) begin
          st_nxt = ST_ENTRY;
          succ   = 1'b1;
        end
      end
      ST_LOCK: if (tick && lock_q == 7'd1) st_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      onehot_q <= '0;
      disp_q   <= BLANK;
      cnt_q    <= '0;
      tries_q  <= '0;
      code_q   <= DEF_CODE;
      lock_q   <= '0;
      tick_q   <= '0;
    end else begin
      onehot_q <= onehot;
      case (st_q)
        ST_ENTRY, ST_SETNEW: if (acc) begin
          if (is_dig) begin
            if (!full) begin
              disp_q <= shl_w[DW-1:0];
              cnt_q  <= cnt_q + 1'b1;
            end
          end else if (key == K_BKSP) begin
            if (cnt_q != '0) begin
              disp_q <= shr_w[DW+3:4];
              cnt_q  <= cnt_q - 1'b1;
            end
          end else if (key == K_CLEAR) begin
            disp_q <= BLANK;
            cnt_q  <= '0;
          end else if (key == K_ENTER && full) begin
            disp_q <= (st_nxt == ST_OPEN) ? OPENED : BLANK;
            cnt_q  <= '0;
            if (st_q == ST_SETNEW) code_q <= disp_q;
            else if (succ)         tries_q <= '0;
            else if (st_nxt == ST_LOCK) begin
              tries_q <= '0;
              lock_q  <= 7'(LOCK_SECS);
              tick_q  <= '0;
            end else               tries_q <= tries_q + 1'b1;
          end
        end
        ST_OPEN: if (acc) begin
          if (key == K_CLEAR) begin
            disp_q <= BLANK;
            cnt_q  <= '0;
          end else if (key == K_SET) begin
            disp_q <= DASHES;
            cnt_q  <= '0;
          end
        end
        ST_LOCK: begin
          tick_q <= tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            if (lock_q == 7'd1) begin
              lock_q <= '0;
              disp_q <= BLANK;
              cnt_q  <= '0;
            end else lock_q <= lock_q - 1'b1;
          end
        end
      endcase
    end
  end

  // Buzzer sequencer: any accepted key restarts the pattern; SUCC/FAIL win over KEY.
  always_comb begin
    case (pat_q)
      PAT_KEY:  begin pat_last = PW'(CLICK_CYC-1);   half_last = HW'(HALF_KEY-1);  end
      PAT_SUCC: begin pat_last = PW'(3*CLICK_CYC-1); half_last = HW'(HALF_SUCC-1); end
      default:  begin pat_last = PW'(3*CLICK_CYC-1); half_last = HW'(HALF_FAIL-1); end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pat_q  <= PAT_NONE;
      ph_q   <= '0;
      hc_q   <= '0;
      tone_q <= 1'b0;
    end else if (acc) begin
      pat_q  <= fail ? PAT_FAIL : (succ ? PAT_SUCC : PAT_KEY);
      ph_q   <= '0;
      hc_q   <= '0;
      tone_q <= 1'b1;
    end else if (pat_q != PAT_NONE) begin
      if (ph_q == pat_last) pat_q <= PAT_NONE;
      ph_q <= ph_q + 1'b1;
      if (hc_q == half_last) begin
        hc_q   <= '0;
        tone_q <= ~tone_q;
      end else hc_q <= hc_q + 1'b1;
    end
  end

  always_comb begin
    disp   = disp_q;
    if (st_q == ST_LOCK) disp = lk_w[DW-1:0];
    buzzer = (pat_q != PAT_NONE) && tone_q &&
             !(pat_q == PAT_FAIL && ph_q >= PW'(CLICK_CYC) && ph_q < PW'(2*CLICK_CYC));
  end

  assign state     = st_q;
  assign tries     = tries_q;
  assign lock_secs = lock_q;
  assign code_out  = code_q;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: queue-based behavioural model checked every cycle,
// plus directed key sequences with hand-computed expectations.
module tb_keypad_lock_ctrl;
  localparam int D = 3, CLK_HZ = 1000, MAXT = 3, LOCKS = 20, CLICK = 30, HALF = 3;
  localparam logic [11:0] DEF = 12'h246;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] onehot = 16'h0000;
  logic [11:0] disp, code_out;
  logic [1:0]  state;
  logic [3:0]  tries;
  logic [6:0]  lock_secs;
  logic        buzzer;

  keypad_lock_ctrl #(.DIGITS(D), .CLK_HZ(CLK_HZ), .MAX_TRIES(MAXT), .LOCK_SECS(LOCKS),
    .DEF_CODE(DEF), .CLICK_CYC(CLICK), .HALF_KEY(HALF), .HALF_SUCC(HALF), .HALF_FAIL(HALF))
  dut (.clk(clk), .RST(RST), .onehot(onehot), .disp(disp), .state(state), .tries(tries),
       .lock_secs(lock_secs), .code_out(code_out), .buzzer(buzzer));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: entered digits as a queue, times as absolute edge numbers.
  int cyc = 0;
  bit started = 0;
  int mst, mtries, lk_start, pat, pstart;
  int dq[$];
  int mcode[$];
  logic [15:0] prev;
  int kmap [16] = '{10, -1, -1, 0, 11, 3, 2, 1, 12, 6, 5, 4, 13, 9, 8, 7};

  function automatic int keyof(input logic [15:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 16; i++) if (v[i]) return kmap[i];
    return -1;
  endfunction

  function automatic bit same_code();
    for (int i = 0; i < D; i++) if (dq[i] != mcode[i]) return 0;
    return 1;
  endfunction

  task automatic m_reset();
    mst = 0; mtries = 0; pat = 0; prev = 16'h0000;
    dq.delete(); mcode.delete();
    for (int i = D-1; i >= 0; i--) mcode.push_back(int'(DEF[4*i +: 4]));
  endtask

  task automatic model_key(input int k);
    pat = 1; pstart = cyc;
    case (mst)
      0, 2: begin
        if (k <= 9) begin
          if (dq.size() < D) dq.push_back(k);
        end else if (k == 13) begin
          if (dq.size() > 0) void'(dq.pop_back());
        end else if (k == 12) begin
          dq.delete(); mst = 0;
        end else if (k == 10 && dq.size() == D) begin
          if (mst == 2) begin
            mcode = dq; mst = 0; pat = 2;
          end else if (same_code()) begin
            mst = 1; mtries = 0; pat = 2;
          end else begin
            pat = 3; mtries++;
            if (mtries == MAXT) begin mst = 3; mtries = 0; lk_start = cyc; end
          end
          dq.delete();
        end
      end
      1: begin
        if (k == 12) begin mst = 0; dq.delete(); end
        else if (k == 11) begin mst = 2; dq.delete(); end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    int k;
    cyc++;
    if (RST) begin
      m_reset();
      started = 1;
    end else begin
      k = keyof(onehot);
      if (prev != 16'h0000) k = -1;
      prev = onehot;
      if (mst == 3) begin
        if (cyc - lk_start == LOCKS*CLK_HZ) mst = 0;
      end else if (k >= 0) model_key(k);
    end
  end

  function automatic int exp_lock();
    return (mst == 3) ? LOCKS - (cyc - lk_start) / CLK_HZ : 0;
  endfunction

  function automatic logic [11:0] exp_disp();
    logic [11:0] r;
    int n, s;
    n = dq.size();
    s = exp_lock();
    for (int i = 0; i < D; i++) begin
      if (mst == 1)           r[4*i +: 4] = 4'hA;
      else if (mst == 3)      r[4*i +: 4] = (i == 0) ? 4'(s % 10) : (i == 1) ? 4'(s / 10) : 4'hF;
      else if (i < n)         r[4*i +: 4] = 4'(dq[n-1-i]);
      else                    r[4*i +: 4] = (mst == 2) ? 4'hD : 4'hF;
    end
    return r;
  endfunction

  function automatic logic [11:0] exp_code();
    logic [11:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'(mcode[D-1-i]);
    return r;
  endfunction

  function automatic logic exp_buz();
    int ph, len;
    if (pat == 0) return 1'b0;
    ph  = cyc - pstart;
    len = (pat == 1) ? CLICK : 3*CLICK;
    if (ph >= len) return 1'b0;
    if (pat == 3 && ph >= CLICK && ph < 2*CLICK) return 1'b0;
    return ((ph / HALF) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (state !== 2'(mst) || disp !== exp_disp() || tries !== 4'(mtries) ||
          lock_secs !== 7'(exp_lock()) || code_out !== exp_code() || buzzer !== exp_buz()) begin
        errors++;
        $display("FAIL model cyc %0d: state %0d want %0d, disp %h want %h, tries %0d want %0d, lock %0d want %0d, code %h want %h, buzzer %0d want %0d",
                 cyc, state, mst, disp, exp_disp(), tries, mtries, lock_secs, exp_lock(),
                 code_out, exp_code(), buzzer, exp_buz());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    onehot = 16'(1 << b);
    step(1);
    onehot = 16'h0000;
    step(2);
  endtask

  // Samples buzzer from the first cycle after the key event, one sample per cycle.
  task automatic press_cnt(input int b, input int hold, input int win, output int highs);
    highs = 0;
    onehot = 16'(1 << b);
    step(1);
    for (int i = 0; i < win; i++) begin
      if (buzzer) highs++;
      if (i + 1 == hold) onehot = 16'h0000;
      step(1);
    end
    onehot = 16'h0000;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h, n;
    step(3);
    chk("rst_disp", 32'(disp), 32'hFFF);
    chk("rst_state", 32'(state), 0);
    chk("rst_code", 32'(code_out), 32'h246);
    chk("rst_buzzer", 32'(buzzer), 0);
    RST = 1'b0;
    step(1);

    press(6);
    chk("first_digit", 32'(disp), 32'hFF2);
    press(11); press(9);
    chk("entered_246", 32'(disp), 32'h246);
    press_cnt(0, 1, 120, h);
    chk("succ_highs", 32'(h), 45);
    chk("open_state", 32'(state), 1);
    chk("open_disp", 32'(disp), 32'hAAA);
    chk("open_tries", 32'(tries), 0);
    press(8);
    chk("clear_state", 32'(state), 0);
    chk("clear_disp", 32'(disp), 32'hFFF);

    for (int t = 1; t <= 3; t++) begin
      press(7); press(6); press(5);
      press_cnt(0, 1, 120, h);
      chk("fail_highs", 32'(h), 30);
      if (t < 3) chk("fail_tries", 32'(tries), 32'(t));
    end
    chk("lock_state", 32'(state), 3);
    chk("lock_secs", 32'(lock_secs), 20);
    chk("lock_disp", 32'(disp), 32'hF20);
    chk("lock_tries", 32'(tries), 0);
    press_cnt(7, 1, 20, h);
    chk("lock_noclick", 32'(h), 0);
    n = 141;
    while (state == 2'd3 && n < 25000) begin
      if (n == 10500) chk("lock_mid_disp", 32'(disp), 32'hF10);
      step(1);
      n++;
    end
    chk("lock_len", 32'(n), 20000);
    chk("unlock_disp", 32'(disp), 32'hFFF);
    chk("unlock_secs", 32'(lock_secs), 0);

    step(50);
    press_cnt(15, 500, 500, h);
    chk("hold_click_highs", 32'(h), 15);
    chk("hold_one_digit", 32'(disp), 32'hFF7);
    onehot = 16'h00C0;
    step(5);
    onehot = 16'h0000;
    step(2);
    chk("multihot_disp", 32'(disp), 32'hFF7);
    chk("multihot_buzzer", 32'(buzzer), 0);

    press(8);
    press(10);
    chk("bksp_pre", 32'(disp), 32'hFF5);
    press(12);
    chk("bksp_post", 32'(disp), 32'hFFF);
    press(14); press(13); press(7); press(15);
    chk("full_ignore", 32'(disp), 32'h891);
    press(8);
    chk("clear_blank", 32'(disp), 32'hFFF);

    press(6); press(11); press(9); press(0);
    chk("reopen", 32'(state), 1);
    press(4);
    chk("set_state", 32'(state), 2);
    chk("set_disp", 32'(disp), 32'hDDD);
    press(7);
    chk("set_partial", 32'(disp), 32'hDD1);
    press(5); press(10);
    chk("set_full", 32'(disp), 32'h135);
    press(0);
    chk("new_code", 32'(code_out), 32'h135);
    chk("new_state", 32'(state), 0);
    press(6); press(11); press(9); press(0);
    chk("old_code_fails", 32'(tries), 1);
    press(7); press(5); press(10); press(0);
    chk("new_code_opens", 32'(state), 1);
    chk("new_code_tries", 32'(tries), 0);
    press(8);

    for (int t = 0; t < 3; t++) begin
      press(7); press(6); press(5); press(0);
    end
    chk("pre_rst_state", 32'(state), 3);
    chk("pre_rst_buzzer", 32'(buzzer), 1);
    RST = 1'b1;
    step(1);
    chk("rst_lock_state", 32'(state), 0);
    chk("rst_lock_disp", 32'(disp), 32'hFFF);
    chk("rst_lock_buzzer", 32'(buzzer), 0);
    chk("rst_lock_secs", 32'(lock_secs), 0);
    chk("rst_lock_code", 32'(code_out), 32'h246);
    RST = 1'b0;
    step(1);
    press(6); press(11); press(9); press(0);
    chk("def_code_back", 32'(state), 1);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
